// File: rtl/gpio_peripheral.sv
// MMIO GPIO block: set/clear/toggle outputs, inverted and synchronised inputs, edge-latched IRQ.
// Define GPIO_DEBOUNCE_EN to add the prescaled per-bit input debouncer.
module gpio_peripheral #(
    parameter int unsigned      N_OUT          = 2,
    parameter int unsigned      N_IN           = 2,
    parameter logic [N_OUT-1:0] OUT_RESET      = '0,
    parameter logic [N_IN-1:0]  IN_INVERT      = {N_IN{1'b1}},
    parameter int unsigned      DEBOUNCE_DIV   = 50000,
    parameter int unsigned      DEBOUNCE_TICKS = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mmio_valid,
    input  logic             mmio_write,
    input  logic [31:0]      mmio_addr,
    input  logic [31:0]      mmio_wdata,
    input  logic [3:0]       mmio_wstrb,
    output logic [31:0]      mmio_rdata,
    output logic             mmio_ready,
    output logic [N_OUT-1:0] gpio_out,
    input  logic [N_IN-1:0]  gpio_in,
    output logic             gpio_irq
);

    localparam logic [2:0] ADDR_OUT    = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_TGL    = 3'd3;
    localparam logic [2:0] ADDR_IN     = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;
    localparam logic [2:0] ADDR_RISE   = 3'd6;
    localparam logic [2:0] ADDR_FALL   = 3'd7;

    logic [N_OUT-1:0] out_q, out_d;
    logic [N_IN-1:0]  rise_en_q, rise_en_d;
    logic [N_IN-1:0]  fall_en_q, fall_en_d;
    logic [N_IN-1:0]  status_q, status_d;
    logic [N_IN-1:0]  sync1_q, sync2_q;
    logic [N_IN-1:0]  deb;
    logic [N_IN-1:0]  deb_prev_q;
    logic [N_IN-1:0]  rise, fall, w1c;
    logic [31:0]      rdata_q, rdata_d;
    logic             ready_q;
    logic             irq_q;
    logic [31:0]      bmask, wd;
    logic [2:0]       idx;
    logic             accept, wr, rd;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bmask[8*k +: 8] = {8{mmio_wstrb[k]}};
        end
    end

    assign wd     = mmio_wdata & bmask;
    assign idx    = mmio_addr[4:2];
    assign accept = mmio_valid && !ready_q;
    assign wr     = accept && mmio_write;
    assign rd     = accept && !mmio_write;

    // Input path: inversion ahead of the two-flop synchroniser.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in ^ IN_INVERT;
            sync2_q <= sync1_q;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned PW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);

    logic [PW-1:0] presc_q;
    logic          tick;

    assign tick = (presc_q == PW'(DEBOUNCE_DIV - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_deb
        logic [CW-1:0] cnt_q;
        logic          deb_bit_q;

        // Any tick that sees the input agree with the debounced value restarts the count.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                cnt_q     <= '0;
                deb_bit_q <= 1'b0;
            end else if (tick) begin
                if (sync2_q[i] == deb_bit_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                    cnt_q     <= '0;
                    deb_bit_q <= sync2_q[i];
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign deb[i] = deb_bit_q;
    end
`else
    assign deb = sync2_q;

    logic unused_params;
    assign unused_params = ^{DEBOUNCE_DIV, DEBOUNCE_TICKS};
`endif

    assign rise = deb & ~deb_prev_q;
    assign fall = ~deb & deb_prev_q;

    always_comb begin
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        rdata_d   = '0;

        if (wr) begin
            unique case (idx)
                ADDR_OUT:    out_d = (out_q & ~bmask[N_OUT-1:0]) | wd[N_OUT-1:0];
                ADDR_SET:    out_d = out_q | wd[N_OUT-1:0];
                ADDR_CLR:    out_d = out_q & ~wd[N_OUT-1:0];
                ADDR_TGL:    out_d = out_q ^ wd[N_OUT-1:0];
                ADDR_STATUS: w1c = wd[N_IN-1:0];
                ADDR_RISE:   rise_en_d = (rise_en_q & ~bmask[N_IN-1:0]) | wd[N_IN-1:0];
                ADDR_FALL:   fall_en_d = (fall_en_q & ~bmask[N_IN-1:0]) | wd[N_IN-1:0];
                default:     ;
            endcase
        end

        if (rd) begin
            unique case (idx)
                ADDR_OUT, ADDR_SET, ADDR_CLR, ADDR_TGL: rdata_d = 32'(out_q);
                ADDR_IN:     rdata_d = 32'(deb);
                ADDR_STATUS: rdata_d = 32'(status_q);
                ADDR_RISE:   rdata_d = 32'(rise_en_q);
                ADDR_FALL:   rdata_d = 32'(fall_en_q);
                default:     rdata_d = '0;
            endcase
        end

        // Edge set is ORed in after the clear, so a coincident edge wins.
        status_d = (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q      <= OUT_RESET;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            deb_prev_q <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            deb_prev_q <= deb;
            rdata_q    <= rdata_d;
            ready_q    <= accept;
            irq_q      <= |status_q;
        end
    end

    assign mmio_rdata = rdata_q;
    assign mmio_ready = ready_q;
    assign gpio_out   = out_q;
    assign gpio_irq   = irq_q;

    logic unused_bits;
    assign unused_bits = ^{mmio_addr[31:5], mmio_addr[1:0], wd, bmask};

endmodule

// File: tb/tb_gpio_peripheral.sv
// Self-checking bench for gpio_peripheral: table-driven register accesses scored through a
// read-data queue, plus hand-timed sequences for edges, IRQ lag, set-wins and reset.
module tb_gpio_peripheral;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mmio_valid, mmio_write;
    logic [31:0] mmio_addr, mmio_wdata;
    logic [3:0]  mmio_wstrb;
    logic [31:0] mmio_rdata;
    logic        mmio_ready;
    logic [1:0]  gpio_out;
    logic [1:0]  gpio_in;
    logic        gpio_irq;

    int tests = 0;
    int fails = 0;

`ifdef GPIO_DEBOUNCE_EN
    localparam int SETTLE = 40;
`else
    localparam int SETTLE = 6;
`endif

    gpio_peripheral #(
        .N_OUT(2),
        .N_IN(2),
        .OUT_RESET(2'b00),
        .IN_INVERT(2'b11),
        .DEBOUNCE_DIV(4),
        .DEBOUNCE_TICKS(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .mmio_valid(mmio_valid),
        .mmio_write(mmio_write),
        .mmio_addr(mmio_addr),
        .mmio_wdata(mmio_wdata),
        .mmio_wstrb(mmio_wstrb),
        .mmio_rdata(mmio_rdata),
        .mmio_ready(mmio_ready),
        .gpio_out(gpio_out),
        .gpio_in(gpio_in),
        .gpio_irq(gpio_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic [31:0] data;
        string       name;
    } sb_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rexp;
        logic [1:0]  oexp;
        string       name;
    } vec_t;

    sb_t  sb_q[$];
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard side: every ready pulse consumes one expected entry.
    always @(negedge clk) begin
        if (mmio_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_ready", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.chk) check(e.name, mmio_rdata, e.data);
            end
        end
    end

    task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] rexp, input string name);
        sb_t e;
        @(negedge clk);
        mmio_valid = 1'b1;
        mmio_write = wr;
        mmio_addr  = addr;
        mmio_wdata = wdata;
        mmio_wstrb = strb;
        e.chk  = !wr;
        e.data = rexp;
        e.name = name;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        mmio_valid = 1'b0;
        mmio_write = 1'b0;
        @(negedge clk);
        check({name, "_ready"}, {31'b0, mmio_ready}, 32'd1);
    endtask

    task automatic wait_irq(input logic lvl, input int lim, input string name);
        int n = 0;
        while (gpio_irq !== lvl && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, gpio_irq}, {31'b0, lvl});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        mmio_valid = 1'b0;
        mmio_write = 1'b0;
        mmio_addr  = '0;
        mmio_wdata = '0;
        mmio_wstrb = '0;
        gpio_in    = 2'b11;

        tbl.push_back('{1'b0, 32'h00, 32'h0,         4'hF, 32'h0, 2'b00, "rd_out_reset"});
        tbl.push_back('{1'b0, 32'h10, 32'h0,         4'hF, 32'h0, 2'b00, "rd_in_idle"});
        tbl.push_back('{1'b1, 32'h00, 32'h1,         4'hF, 32'h0, 2'b01, "wr_out"});
        tbl.push_back('{1'b1, 32'h04, 32'h2,         4'hF, 32'h0, 2'b11, "set"});
        tbl.push_back('{1'b1, 32'h08, 32'h1,         4'hF, 32'h0, 2'b10, "clr"});
        tbl.push_back('{1'b1, 32'h0C, 32'h3,         4'hF, 32'h0, 2'b01, "tgl"});
        tbl.push_back('{1'b0, 32'h0C, 32'h0,         4'hF, 32'h1, 2'b01, "rd_tgl_alias"});
        tbl.push_back('{1'b1, 32'h00, 32'hFFFF_FFFF, 4'h0, 32'h0, 2'b01, "wr_strb0"});
        tbl.push_back('{1'b1, 32'h00, 32'hFFFF_FF02, 4'hE, 32'h0, 2'b01, "wr_lane0_off"});
        tbl.push_back('{1'b1, 32'h0C, 32'h3,         4'h1, 32'h0, 2'b10, "tgl_lane0"});
        tbl.push_back('{1'b0, 32'h00, 32'h0,         4'hF, 32'h2, 2'b10, "rd_out"});
        tbl.push_back('{1'b1, 32'h00, 32'hFFFF_FFFF, 4'h1, 32'h0, 2'b11, "wr_all"});
        tbl.push_back('{1'b0, 32'h00, 32'h0,         4'hF, 32'h3, 2'b11, "rd_out_upper0"});
        tbl.push_back('{1'b1, 32'h18, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b11, "wr_rise_en"});
        tbl.push_back('{1'b0, 32'h18, 32'h0,         4'hF, 32'h3, 2'b11, "rd_rise_en"});
        tbl.push_back('{1'b1, 32'h1C, 32'hFFFF_FFFE, 4'hF, 32'h0, 2'b11, "wr_fall_en"});
        tbl.push_back('{1'b0, 32'h1C, 32'h0,         4'hF, 32'h2, 2'b11, "rd_fall_en"});
        tbl.push_back('{1'b0, 32'h14, 32'h0,         4'hF, 32'h0, 2'b11, "rd_status_idle"});
        tbl.push_back('{1'b1, 32'h18, 32'h1,         4'hF, 32'h0, 2'b11, "rise_en0"});
        tbl.push_back('{1'b1, 32'h1C, 32'h0,         4'hF, 32'h0, 2'b11, "fall_en_off"});
        tbl.push_back('{1'b0, 32'h10, 32'h0,         4'hF, 32'h0, 2'b11, "rd_in_idle2"});

        repeat (3) @(negedge clk);
        check("rst_out",   {30'b0, gpio_out},   32'h0);
        check("rst_ready", {31'b0, mmio_ready}, 32'h0);
        check("rst_rdata", mmio_rdata,          32'h0);
        check("rst_irq",   {31'b0, gpio_irq},   32'h0);
        resetn = 1'b1;
        repeat (SETTLE) @(negedge clk);

        foreach (tbl[i]) begin
            bus(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, tbl[i].rexp, tbl[i].name);
            check({tbl[i].name, "_out"}, {30'b0, gpio_out}, {30'b0, tbl[i].oexp});
        end
        check("irq_idle", {31'b0, gpio_irq}, 32'h0);

        // Press bit 0 with RISE_EN[0] set.
        @(negedge clk);
        gpio_in[0] = 1'b0;
        wait_irq(1'b1, SETTLE, "irq_on_rise");
        bus(1'b0, 32'h14, 32'h0, 4'hF, 32'h1, "rd_status_rise");
        bus(1'b0, 32'h10, 32'h0, 4'hF, 32'h1, "rd_in_pressed");
        bus(1'b1, 32'h14, 32'h1, 4'hF, 32'h0, "w1c_status");
        check("irq_lags_clear", {31'b0, gpio_irq}, 32'h1);
        @(negedge clk);
        check("irq_cleared", {31'b0, gpio_irq}, 32'h0);
        bus(1'b0, 32'h14, 32'h0, 4'hF, 32'h0, "rd_status_cleared");

        // Release: falling edge with FALL_EN = 0 must not record.
        @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (SETTLE) @(negedge clk);
        bus(1'b0, 32'h10, 32'h0, 4'hF, 32'h0, "rd_in_released");
        bus(1'b0, 32'h14, 32'h0, 4'hF, 32'h0, "rd_status_no_fall");
        check("irq_no_fall", {31'b0, gpio_irq}, 32'h0);

`ifndef GPIO_DEBOUNCE_EN
        // Rising edge lands on the W1C acceptance edge: three posedges after the pin change.
        @(negedge clk);
        gpio_in[0] = 1'b0;
        @(negedge clk);
        bus(1'b1, 32'h14, 32'h1, 4'hF, 32'h0, "w1c_vs_rise");
        bus(1'b0, 32'h14, 32'h0, 4'hF, 32'h1, "rd_status_set_wins");
        wait_irq(1'b1, 4, "irq_set_wins");
`else
        @(negedge clk);
        gpio_in[0] = 1'b0;
        wait_irq(1'b1, SETTLE, "irq_rise_deb");
`endif

        // Reset during a read: no ready pulse, everything back to reset values.
        @(negedge clk);
        mmio_valid = 1'b1;
        mmio_write = 1'b0;
        mmio_addr  = 32'h10;
        #2;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        mmio_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", {31'b0, mmio_ready}, 32'h0);
        check("mid_rst_out",   {30'b0, gpio_out},   32'h0);
        check("mid_rst_rdata", mmio_rdata,          32'h0);
        check("mid_rst_irq",   {31'b0, gpio_irq},   32'h0);
        @(negedge clk);
        resetn     = 1'b1;
        gpio_in[0] = 1'b1;
        repeat (SETTLE) @(negedge clk);
        bus(1'b0, 32'h18, 32'h0, 4'hF, 32'h0, "rd_rise_en_rst");
        bus(1'b0, 32'h00, 32'h0, 4'hF, 32'h0, "rd_out_rst");
        bus(1'b0, 32'h14, 32'h0, 4'hF, 32'h0, "rd_status_rst");

`ifdef GPIO_DEBOUNCE_EN
        bus(1'b1, 32'h18, 32'h1, 4'hF, 32'h0, "deb_rise_en");
        @(negedge clk);
        gpio_in[0] = 1'b0;
        repeat (10) @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (30) @(negedge clk);
        bus(1'b0, 32'h10, 32'h0, 4'hF, 32'h0, "deb_glitch_in");
        bus(1'b0, 32'h14, 32'h0, 4'hF, 32'h0, "deb_glitch_status");
        @(negedge clk);
        gpio_in[0] = 1'b0;
        wait_irq(1'b1, 4 * 4 + 3 + 4, "deb_held_irq");
        bus(1'b0, 32'h10, 32'h0, 4'hF, 32'h1, "deb_held_in");
`endif

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
